// File: rtl/beat_seq_pkg.sv
// beat_seq_pkg: shared types and helpers for the beat sequencer.
//   beat_state_e : sequencer state encoding
//   clamp_beat   : limits a requested beat to the last valid index
package beat_seq_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    PLAY  = 2'd1,
    LOOP  = 2'd2,
    DONE  = 2'd3
  } beat_state_e;

  // Operands are widened to 32 bits so the helper stays independent of BEAT_W.
  function automatic logic [31:0] clamp_beat(input logic [31:0] beat,
                                             input logic [31:0] last);
    return (beat > last) ? last : beat;
  endfunction

endpackage

// File: rtl/beat_loop_calc.sv
// beat_loop_calc: combinational loop-bound computation.
//   ibeat      in  BEAT_W  current beat index
//   loop_notes in  LW_W    loop span in notes (0 behaves as 1)
//   loop_start out BEAT_W  first beat of the loop
//   loop_end   out BEAT_W  last beat of the loop (end of the current note)
module beat_loop_calc #(
  parameter int LEN    = 4095,
  parameter int BEAT_W = 12,
  parameter int BPN    = 4,
  parameter int LW_W   = 3
) (
  input  logic [BEAT_W-1:0] ibeat,
  input  logic [LW_W-1:0]   loop_notes,
  output logic [BEAT_W-1:0] loop_start,
  output logic [BEAT_W-1:0] loop_end
);

  // Wide enough that end+1 and N*BPN never wrap.
  localparam int W = BEAT_W + LW_W + 1;

  logic [W-1:0] note_end;
  logic [W-1:0] end_w;
  logic [W-1:0] notes;
  logic [W-1:0] span;
  logic [W-1:0] end_p1;
  logic [W-1:0] start_w;

  always_comb begin
    note_end = W'(ibeat) | W'(BPN - 1);
    end_w    = (note_end > W'(LEN - 1)) ? W'(LEN - 1) : note_end;
    notes    = (loop_notes == '0) ? W'(1) : W'(loop_notes);
    span     = notes * W'(BPN);
    end_p1   = end_w + W'(1);
    // Loop is truncated at beat 0 when the span reaches before song start.
    start_w  = (end_p1 >= span) ? (end_p1 - span) : '0;
  end

  assign loop_end   = BEAT_W'(end_w);
  assign loop_start = BEAT_W'(start_w);

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: beat-position sequencer with play/pause, seek,
// end-of-song stop/repeat and note-aligned A-B looping.
//   clk, rst_n            clock, async active-low reset
//   beat_tick             one-cycle advance strobe
//   play                  level, 1 = play
//   loop_en               rising edge arms loop, low exits
//   loop_notes            loop span in notes
//   repeat_en             wrap at song end instead of stopping
//   seek_valid, seek_beat one-cycle seek request and target
//   ibeat                 current beat index
//   loop_start, loop_end  captured loop bounds
//   looping, done         state flags
//   song_end              pulse after a tick past the last beat
//
// state | meaning
// PAUSE | holding position, ticks ignored
// PLAY  | advancing on ticks, stop or wrap at song end
// LOOP  | advancing between loop_start and loop_end (ticks gated by play)
// DONE  | stopped at last beat, waiting for play edge or seek
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int LEN    = 4095,
  parameter int BEAT_W = 12,
  parameter int BPN    = 4,
  parameter int LW_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_tick,
  input  logic              play,
  input  logic              loop_en,
  input  logic [LW_W-1:0]   loop_notes,
  input  logic              repeat_en,
  input  logic              seek_valid,
  input  logic [BEAT_W-1:0] seek_beat,
  output logic [BEAT_W-1:0] ibeat,
  output logic [BEAT_W-1:0] loop_start,
  output logic [BEAT_W-1:0] loop_end,
  output logic              looping,
  output logic              done,
  output logic              song_end
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LEN - 1);

  beat_state_e       state, state_n;
  logic [BEAT_W-1:0] ibeat_n, loop_start_n, loop_end_n;
  logic [BEAT_W-1:0] calc_start, calc_end, seek_clamped;
  logic              song_end_n;
  logic              loop_en_q, play_q;
  logic              loop_rise, play_rise;

  beat_loop_calc #(
    .LEN(LEN), .BEAT_W(BEAT_W), .BPN(BPN), .LW_W(LW_W)
  ) u_loop_calc (
    .ibeat      (ibeat),
    .loop_notes (loop_notes),
    .loop_start (calc_start),
    .loop_end   (calc_end)
  );

  assign loop_rise    = loop_en & ~loop_en_q;
  assign play_rise    = play & ~play_q;
  assign seek_clamped = BEAT_W'(clamp_beat(32'(seek_beat), 32'(LAST)));
  assign looping      = (state == LOOP);
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PAUSE;
      ibeat      <= '0;
      loop_start <= '0;
      loop_end   <= '0;
      song_end   <= 1'b0;
      // Reset high so a loop_en held through reset does not arm a loop.
      loop_en_q  <= 1'b1;
      play_q     <= 1'b0;
    end else begin
      state      <= state_n;
      ibeat      <= ibeat_n;
      loop_start <= loop_start_n;
      loop_end   <= loop_end_n;
      song_end   <= song_end_n;
      loop_en_q  <= loop_en;
      play_q     <= play;
    end
  end

  always_comb begin
    state_n      = state;
    ibeat_n      = ibeat;
    loop_start_n = loop_start;
    loop_end_n   = loop_end;
    song_end_n   = 1'b0;

    if (seek_valid) begin
      ibeat_n = seek_clamped;
      if (state == LOOP || state == DONE)
        state_n = play ? PLAY : PAUSE;
    end else if (state == LOOP && !loop_en) begin
      state_n = play ? PLAY : PAUSE;
    end else begin
      // Entry captures bounds from the pre-tick position; a tick in the
      // same cycle still follows linear PLAY rules below.
      if ((state == PLAY || state == PAUSE) && loop_rise) begin
        loop_start_n = calc_start;
        loop_end_n   = calc_end;
        state_n      = LOOP;
      end
      case (state)
        PAUSE: begin
          if (play && !loop_rise)
            state_n = PLAY;
        end
        PLAY: begin
          if (!play) begin
            if (!loop_rise)
              state_n = PAUSE;
          end else if (beat_tick) begin
            if (ibeat == LAST) begin
              song_end_n = 1'b1;
              if (repeat_en)
                ibeat_n = '0;
              else if (!loop_rise)
                state_n = DONE;
            end else begin
              ibeat_n = ibeat + BEAT_W'(1);
            end
          end
        end
        LOOP: begin
          // Also wrap at the song end in case a linear tick on entry
          // carried ibeat past loop_end.
          if (play && beat_tick) begin
            if (ibeat == loop_end || ibeat == LAST)
              ibeat_n = loop_start;
            else
              ibeat_n = ibeat + BEAT_W'(1);
          end
        end
        DONE: begin
          if (play_rise) begin
            ibeat_n = '0;
            state_n = PLAY;
          end
        end
        default: state_n = PAUSE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
module tb_beat_sequencer;

  logic        clk;
  logic        rst_n;
  logic        beat_tick;
  logic        play;
  logic        loop_en;
  logic [2:0]  loop_notes;
  logic        repeat_en;
  logic        seek_valid;
  logic [11:0] seek_beat;

  logic [11:0] ibeat_a, ls_a, le_a, ibeat_b, ls_b, le_b;
  logic        looping_a, done_a, se_a, looping_b, done_b, se_b;

  beat_sequencer #(.LEN(16), .BEAT_W(12), .BPN(4), .LW_W(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .beat_tick(beat_tick), .play(play),
    .loop_en(loop_en), .loop_notes(loop_notes), .repeat_en(repeat_en),
    .seek_valid(seek_valid), .seek_beat(seek_beat),
    .ibeat(ibeat_a), .loop_start(ls_a), .loop_end(le_a),
    .looping(looping_a), .done(done_a), .song_end(se_a)
  );

  beat_sequencer #(.LEN(10), .BEAT_W(12), .BPN(4), .LW_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .beat_tick(beat_tick), .play(play),
    .loop_en(loop_en), .loop_notes(loop_notes), .repeat_en(repeat_en),
    .seek_valid(seek_valid), .seek_beat(seek_beat),
    .ibeat(ibeat_b), .loop_start(ls_b), .loop_end(le_b),
    .looping(looping_b), .done(done_b), .song_end(se_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string tag;
    bit    b;
    int    ibeat;
    int    looping;
    int    done;
    int    song_end;
    int    ls;
    int    le;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected post-edge state; ls/le of -1 skip the bound comparison.
  task automatic expect_st(input string tag, input bit b, input int ib,
                           input int lp, input int dn, input int se,
                           input int ls = -1, input int le = -1);
    exp_t e;
    e.tag = tag; e.b = b; e.ibeat = ib; e.looping = lp;
    e.done = dn; e.song_end = se; e.ls = ls; e.le = le;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.b) begin
        check_eq({e.tag, ".ibeat"},    int'(ibeat_a),   e.ibeat);
        check_eq({e.tag, ".looping"},  int'(looping_a), e.looping);
        check_eq({e.tag, ".done"},     int'(done_a),    e.done);
        check_eq({e.tag, ".song_end"}, int'(se_a),      e.song_end);
        if (e.ls >= 0) check_eq({e.tag, ".loop_start"}, int'(ls_a), e.ls);
        if (e.le >= 0) check_eq({e.tag, ".loop_end"},   int'(le_a), e.le);
      end else begin
        check_eq({e.tag, ".ibeat"},    int'(ibeat_b),   e.ibeat);
        check_eq({e.tag, ".looping"},  int'(looping_b), e.looping);
        check_eq({e.tag, ".done"},     int'(done_b),    e.done);
        check_eq({e.tag, ".song_end"}, int'(se_b),      e.song_end);
        if (e.ls >= 0) check_eq({e.tag, ".loop_start"}, int'(ls_b), e.ls);
        if (e.le >= 0) check_eq({e.tag, ".loop_end"},   int'(le_b), e.le);
      end
    end
  endtask

  // One clock with the given strobes; outputs sampled 1 time unit after the edge.
  task automatic go(input bit t, input bit sv, input logic [11:0] sbt);
    beat_tick  = t;
    seek_valid = sv;
    seek_beat  = sbt;
    @(posedge clk);
    #1;
    beat_tick  = 1'b0;
    seek_valid = 1'b0;
    drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; beat_tick = 1'b0; play = 1'b0; loop_en = 1'b0;
    loop_notes = 3'd0; repeat_en = 1'b0; seek_valid = 1'b0; seek_beat = '0;
    #12;
    rst_n = 1'b1;
    expect_st("reset", 0, 0, 0, 0, 0, 0, 0);
    drain();

    // Linear play
    play = 1'b1;
    expect_st("to_play", 0, 0, 0, 0, 0);
    go(0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      expect_st($sformatf("tick%0d", i), 0, i, 0, 0, 0);
      go(1, 0, 0);
    end

    // Song end, stop
    expect_st("seek14", 0, 14, 0, 0, 0);
    go(0, 1, 12'd14);
    expect_st("tick15", 0, 15, 0, 0, 0);
    go(1, 0, 0);
    expect_st("song_end", 0, 15, 0, 1, 1);
    go(1, 0, 0);
    expect_st("done_ignore", 0, 15, 0, 1, 0);
    go(1, 0, 0);
    play = 1'b0;
    expect_st("done_pause", 0, 15, 0, 1, 0);
    go(0, 0, 0);
    play = 1'b1;
    expect_st("replay", 0, 0, 0, 0, 0);
    go(0, 0, 0);

    // Song end, repeat
    repeat_en = 1'b1;
    expect_st("seek15", 0, 15, 0, 0, 0);
    go(0, 1, 12'd15);
    expect_st("repeat_wrap", 0, 0, 0, 0, 1);
    go(1, 0, 0);
    expect_st("repeat_pulse", 0, 0, 0, 0, 0);
    go(0, 0, 0);

    // Loop 2 notes from beat 13
    expect_st("seek13", 0, 13, 0, 0, 0);
    go(0, 1, 12'd13);
    loop_notes = 3'd2;
    loop_en = 1'b1;
    expect_st("entry", 0, 13, 1, 0, 0, 8, 15);
    go(0, 0, 0);
    loop_notes = 3'd5;
    expect_st("loop14", 0, 14, 1, 0, 0, 8, 15);
    go(1, 0, 0);
    expect_st("loop15", 0, 15, 1, 0, 0, 8, 15);
    go(1, 0, 0);
    expect_st("loop_wrap", 0, 8, 1, 0, 0, 8, 15);
    go(1, 0, 0);
    expect_st("loop9", 0, 9, 1, 0, 0, 8, 15);
    go(1, 0, 0);
    loop_en = 1'b0;
    expect_st("exit", 0, 9, 0, 0, 0, 8, 15);
    go(0, 0, 0);
    expect_st("exit_linear", 0, 10, 0, 0, 0, 8, 15);
    go(1, 0, 0);

    // Loop truncated at beat 0, then seek cancels it
    expect_st("seek1", 0, 1, 0, 0, 0);
    go(0, 1, 12'd1);
    loop_notes = 3'd4;
    loop_en = 1'b1;
    expect_st("entry_trunc", 0, 1, 1, 0, 0, 0, 3);
    go(0, 0, 0);
    expect_st("trunc_tick", 0, 2, 1, 0, 0, 0, 3);
    go(1, 0, 0);
    expect_st("seek_clamp", 0, 15, 0, 0, 0, 0, 3);
    go(1, 1, 12'hFFF);
    expect_st("no_rearm", 0, 15, 0, 0, 0, 0, 3);
    go(0, 0, 0);
    loop_en = 1'b0;

    // Short song: loop end clamps to LEN-1, no song_end in loop
    do_reset();
    expect_st("b_play", 1, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0);
    expect_st("b_seek9", 1, 9, 0, 0, 0);
    go(0, 1, 12'd9);
    loop_notes = 3'd1;
    loop_en = 1'b1;
    expect_st("b_entry", 1, 9, 1, 0, 0, 6, 9);
    go(0, 0, 0);
    expect_st("b_loop_wrap", 1, 6, 1, 0, 0, 6, 9);
    go(1, 0, 0);
    loop_en = 1'b0;
    go(0, 0, 0);

    // Entry and tick in the same cycle, then async reset mid-loop
    do_reset();
    expect_st("c_play", 0, 0, 0, 0, 0);
    go(0, 0, 0);
    expect_st("c_seek7", 0, 7, 0, 0, 0);
    go(0, 1, 12'd7);
    loop_notes = 3'd1;
    loop_en = 1'b1;
    expect_st("entry_tick", 0, 8, 1, 0, 0, 4, 7);
    go(1, 0, 0);
    expect_st("after_entry_tick", 0, 9, 1, 0, 0, 4, 7);
    go(1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("async_rst", 0, 0, 0, 0, 0, 0, 0);
    drain();
    rst_n = 1'b1;
    expect_st("held_loop_en", 0, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0);
    loop_en = 1'b0;
    go(0, 0, 0);
    loop_en = 1'b1;
    expect_st("rearm", 0, 0, 1, 0, 0, 0, 3);
    go(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
